// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned RegAddrWDefault = 4;

  // FSM state encoding
  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMulWait = 2'd1,
    StHalt    = 2'd2
  } hz_state_e;

  // Buffer control bit ordering, MSB first: PC, IF/ID, ID/EX, EX/MEM, MEM/WB
  typedef struct packed {
    logic pc_dis;
    logic ifid_dis;
    logic ifid_flush;
    logic idex_dis;
    logic idex_flush;
    logic exmem_dis;
    logic exmem_flush;
    logic memwb_dis;
    logic memwb_flush;
  } hz_ctrl_t;

  localparam hz_ctrl_t CtrlNone    = hz_ctrl_t'(9'b0_00_00_00_00);
  localparam hz_ctrl_t CtrlReset   = hz_ctrl_t'(9'b0_01_01_01_01);
  // Hold front end, bubble into EX/MEM: multiply wait and halt
  localparam hz_ctrl_t CtrlExStall = hz_ctrl_t'(9'b1_10_10_01_00);
  // Data memory wait: freeze everything up to EX/MEM, bubble into MEM/WB
  localparam hz_ctrl_t CtrlFreeze  = hz_ctrl_t'(9'b1_10_10_10_01);
  localparam hz_ctrl_t CtrlBranch  = hz_ctrl_t'(9'b0_01_01_00_00);
  localparam hz_ctrl_t CtrlLoadUse = hz_ctrl_t'(9'b1_10_01_00_00);

endpackage

// File: rtl/pipeline_hazard_ctrl_down_counter.sv
// Loadable down-counter with freeze and zero flag; tracks remaining multiply cycles.
module hz_down_counter #(
  parameter int unsigned W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Load has priority over decrement; neither means hold
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall/flush sequencer for the five lockBuffer pipeline registers.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = RegAddrWDefault,
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_use_rs1,
  input  logic                  i_id_use_rs2,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_ex_is_load,
  input  logic                  i_ex_branch_taken,
  input  logic                  i_ex_mul_start,
  input  logic                  i_ex_halt,
  input  logic                  i_mem_busy,
  output logic                  o_pc_dis,
  output logic                  o_ifid_dis,
  output logic                  o_ifid_flush,
  output logic                  o_idex_dis,
  output logic                  o_idex_flush,
  output logic                  o_exmem_dis,
  output logic                  o_exmem_flush,
  output logic                  o_memwb_dis,
  output logic                  o_memwb_flush,
  output logic                  o_halted,
  output logic [CNT_W-1:0]      o_stall_cycles
);

  // The multiply's first EX cycle is spent in RUN, the last one releases from MUL_WAIT
  localparam logic [3:0] MulLoad = 4'(MUL_CYCLES - 2);

  hz_state_e        r_state;
  hz_state_e        w_state_d;
  hz_ctrl_t         w_ctrl;
  logic             w_load_use;
  logic             w_cnt_load;
  logic             w_cnt_dec;
  logic             w_cnt_zero;
  logic [3:0]       w_mul_cnt;
  logic [CNT_W-1:0] r_stall;

  hz_down_counter #(
    .W (4)
  ) u_mul_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_cnt_load),
    .i_load_val (MulLoad),
    .i_dec      (w_cnt_dec),
    .o_cnt      (w_mul_cnt),
    .o_zero     (w_cnt_zero)
  );

  // Load-use: the loaded register (never r0) is read by the instruction in ID
  always_comb begin
    w_load_use = i_ex_is_load && (i_ex_rd != '0) &&
                 ((i_id_use_rs1 && (i_id_rs1 == i_ex_rd)) ||
                  (i_id_use_rs2 && (i_id_rs2 == i_ex_rd)));
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StRun;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state and buffer control decode
  always_comb begin
    w_state_d  = r_state;
    w_ctrl     = CtrlNone;
    w_cnt_load = 1'b0;
    w_cnt_dec  = 1'b0;
    if (i_rst) begin
      w_ctrl = CtrlReset;
    end else if (i_mem_busy && (r_state != StHalt)) begin
      // State and mul_cnt frozen while memory is busy
      w_ctrl = CtrlFreeze;
    end else begin
      unique case (r_state)
        StRun: begin
          if (i_ex_halt) begin
            w_ctrl    = CtrlExStall;
            w_state_d = StHalt;
          end else if (i_ex_mul_start) begin
            w_ctrl     = CtrlExStall;
            w_cnt_load = 1'b1;
            w_state_d  = StMulWait;
          end else if (i_ex_branch_taken) begin
            w_ctrl = CtrlBranch;
          end else if (w_load_use) begin
            w_ctrl = CtrlLoadUse;
          end
        end
        StMulWait: begin
          if (!w_cnt_zero) begin
            w_ctrl    = CtrlExStall;
            w_cnt_dec = 1'b1;
          end else begin
            w_state_d = StRun;
          end
        end
        StHalt: begin
          w_ctrl = CtrlExStall;
        end
        default: begin
          w_state_d = StRun;
        end
      endcase
    end
  end

  // Saturating count of front-end stall cycles outside HALT
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall <= '0;
    end else if (w_ctrl.pc_dis && (r_state != StHalt) && (r_stall != '1)) begin
      r_stall <= r_stall + CNT_W'(1);
    end
  end

  assign o_pc_dis       = w_ctrl.pc_dis;
  assign o_ifid_dis     = w_ctrl.ifid_dis;
  assign o_ifid_flush   = w_ctrl.ifid_flush;
  assign o_idex_dis     = w_ctrl.idex_dis;
  assign o_idex_flush   = w_ctrl.idex_flush;
  assign o_exmem_dis    = w_ctrl.exmem_dis;
  assign o_exmem_flush  = w_ctrl.exmem_flush;
  assign o_memwb_dis    = w_ctrl.memwb_dis;
  assign o_memwb_flush  = w_ctrl.memwb_flush;
  assign o_halted       = (r_state == StHalt) && !i_rst;
  assign o_stall_cycles = r_stall;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int MUL = 4;

  // Expected control vectors {pc, ifid dis/flush, idex, exmem, memwb}
  localparam logic [8:0] E_NONE   = 9'b0_00_00_00_00;
  localparam logic [8:0] E_RESET  = 9'b0_01_01_01_01;
  localparam logic [8:0] E_STALL  = 9'b1_10_10_01_00;
  localparam logic [8:0] E_FREEZE = 9'b1_10_10_10_01;
  localparam logic [8:0] E_BRANCH = 9'b0_01_01_00_00;
  localparam logic [8:0] E_LU     = 9'b1_10_01_00_00;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_rs1, id_rs2, ex_rd;
  logic       use_rs1, use_rs2, ex_is_load, br, mul, halt, busy;

  logic        a_pc, a_ifd, a_iff, a_ixd, a_ixf, a_emd, a_emf, a_mwd, a_mwf, a_halted;
  logic [15:0] a_stall;
  logic        s_pc, s_ifd, s_iff, s_ixd, s_ixf, s_emd, s_emf, s_mwd, s_mwf, s_halted;
  logic [3:0]  s_stall;
  logic [8:0]  a_ctrl, s_ctrl;

  logic [15:0] buf_d, ifid_buf, idex_buf;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int     m_age     = 0;  // EX cycles already spent by the multiply in flight (0: none)
  bit     m_halted  = 1'b0;
  longint m_count   = 0;  // unsaturated stall count

  always #5 clk = ~clk;

  assign a_ctrl = {a_pc, a_ifd, a_iff, a_ixd, a_ixf, a_emd, a_emf, a_mwd, a_mwf};
  assign s_ctrl = {s_pc, s_ifd, s_iff, s_ixd, s_ixf, s_emd, s_emf, s_mwd, s_mwf};

  pipeline_hazard_ctrl #(.REG_ADDR_W(4), .MUL_CYCLES(MUL), .CNT_W(16)) dut (
    .i_clk (clk), .i_rst (rst), .i_id_rs1 (id_rs1), .i_id_rs2 (id_rs2),
    .i_id_use_rs1 (use_rs1), .i_id_use_rs2 (use_rs2), .i_ex_rd (ex_rd),
    .i_ex_is_load (ex_is_load), .i_ex_branch_taken (br), .i_ex_mul_start (mul),
    .i_ex_halt (halt), .i_mem_busy (busy),
    .o_pc_dis (a_pc), .o_ifid_dis (a_ifd), .o_ifid_flush (a_iff), .o_idex_dis (a_ixd),
    .o_idex_flush (a_ixf), .o_exmem_dis (a_emd), .o_exmem_flush (a_emf),
    .o_memwb_dis (a_mwd), .o_memwb_flush (a_mwf), .o_halted (a_halted),
    .o_stall_cycles (a_stall)
  );

  pipeline_hazard_ctrl #(.REG_ADDR_W(4), .MUL_CYCLES(MUL), .CNT_W(4)) dut_small (
    .i_clk (clk), .i_rst (rst), .i_id_rs1 (id_rs1), .i_id_rs2 (id_rs2),
    .i_id_use_rs1 (use_rs1), .i_id_use_rs2 (use_rs2), .i_ex_rd (ex_rd),
    .i_ex_is_load (ex_is_load), .i_ex_branch_taken (br), .i_ex_mul_start (mul),
    .i_ex_halt (halt), .i_mem_busy (busy),
    .o_pc_dis (s_pc), .o_ifid_dis (s_ifd), .o_ifid_flush (s_iff), .o_idex_dis (s_ixd),
    .o_idex_flush (s_ixf), .o_exmem_dis (s_emd), .o_exmem_flush (s_emf),
    .o_memwb_dis (s_mwd), .o_memwb_flush (s_mwf), .o_halted (s_halted),
    .o_stall_cycles (s_stall)
  );

  // Two pipeline registers steered by the DUT, standing in for lockBuffer
  always @(posedge clk) begin
    if (a_iff) ifid_buf <= 16'h0000;
    else if (!a_ifd) ifid_buf <= buf_d;
    if (a_ixf) idex_buf <= 16'h0000;
    else if (!a_ixd) idex_buf <= ifid_buf;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: evaluated on every falling edge against current inputs
  always @(negedge clk) begin
    logic [8:0] e;
    logic       lu;
    bit         was_halted;
    longint     sat_b, sat_s;
    was_halted = m_halted;
    lu = ex_is_load && (ex_rd != 4'd0) &&
         ((use_rs1 && id_rs1 == ex_rd) || (use_rs2 && id_rs2 == ex_rd));
    sat_b = (m_count > 65535) ? 65535 : m_count;
    sat_s = (m_count > 15) ? 15 : m_count;
    chk("model stall_cycles", 64'(a_stall), 64'(sat_b));
    chk("model stall_cycles_w4", 64'(s_stall), 64'(sat_s));
    chk("model halted", 64'(a_halted), 64'(was_halted && !rst));
    chk("model halted_w4", 64'(s_halted), 64'(was_halted && !rst));
    if (rst) begin
      e = E_RESET; m_halted = 1'b0; m_age = 0;
    end else if (m_halted) begin
      e = E_STALL;
    end else if (busy) begin
      e = E_FREEZE;
    end else if (m_age > 0) begin
      if (m_age + 1 < MUL) begin e = E_STALL; m_age++; end
      else begin e = E_NONE; m_age = 0; end
    end else if (halt) begin
      e = E_STALL; m_halted = 1'b1;
    end else if (mul) begin
      e = E_STALL; m_age = 1;
    end else if (br) begin
      e = E_BRANCH;
    end else if (lu) begin
      e = E_LU;
    end else begin
      e = E_NONE;
    end
    chk("model ctrl", 64'(a_ctrl), 64'(e));
    chk("model ctrl_w4", 64'(s_ctrl), 64'(e));
    if (rst) m_count = 0;
    else if (e[8] && !was_halted) m_count++;
  end

  task automatic quiet();
    rst = 0; id_rs1 = 0; id_rs2 = 0; use_rs1 = 0; use_rs2 = 0; ex_rd = 0;
    ex_is_load = 0; br = 0; mul = 0; halt = 0; busy = 0;
  endtask

  task automatic set_lu();
    ex_is_load = 1; ex_rd = 4'd3; id_rs2 = 4'd3; use_rs2 = 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    buf_d = 16'h0000;
    // 1: reset with every input high
    rst = 1; id_rs1 = 4'hF; id_rs2 = 4'hF; use_rs1 = 1; use_rs2 = 1; ex_rd = 4'hF;
    ex_is_load = 1; br = 1; mul = 1; halt = 1; busy = 1;
    @(negedge clk); chk("reset ctrl c1", 64'(a_ctrl), 64'(E_RESET));
    @(negedge clk); chk("reset ctrl c2", 64'(a_ctrl), 64'(E_RESET));
    chk("reset halted", 64'(a_halted), 64'(0));
    step(); quiet();
    @(negedge clk); chk("post-reset ctrl", 64'(a_ctrl), 64'(E_NONE));
    chk("post-reset stall", 64'(a_stall), 64'(0));

    // 2: load-use, then the same with rd=r0
    step(); set_lu();
    @(negedge clk); chk("load-use ctrl", 64'(a_ctrl), 64'(E_LU));
    step(); quiet();
    @(negedge clk); chk("load-use clears", 64'(a_ctrl), 64'(E_NONE));
    chk("load-use stall", 64'(a_stall), 64'(1));
    step(); set_lu(); ex_rd = 4'd0; id_rs2 = 4'd0;
    @(negedge clk); chk("r0 no stall", 64'(a_ctrl), 64'(E_NONE));

    // 3: multiply, plain and with a 2-cycle memory wait
    step(); quiet(); mul = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      @(negedge clk); chk("mul ctrl", 64'(a_ctrl), 64'((i < 3) ? E_STALL : E_NONE));
    end
    step(); quiet();
    @(negedge clk); chk("mul stall count", 64'(a_stall), 64'(4));
    step(); mul = 1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      busy = (i == 1 || i == 2);
      @(negedge clk);
      chk("mul+busy ctrl", 64'(a_ctrl),
          64'((i == 1 || i == 2) ? E_FREEZE : (i < 5) ? E_STALL : E_NONE));
    end
    step(); quiet();
    @(negedge clk); chk("mul+busy stall count", 64'(a_stall), 64'(9));

    // 4: branch beats load-use
    step(); set_lu(); br = 1;
    @(negedge clk); chk("branch ctrl", 64'(a_ctrl), 64'(E_BRANCH));
    step(); quiet();
    @(negedge clk); chk("after branch", 64'(a_ctrl), 64'(E_NONE));
    chk("branch stall", 64'(a_stall), 64'(9));

    // Pipeline registers: hold under stall, clear on flush
    step(); buf_d = 16'hAFAF;
    step(); buf_d = 16'h1234; set_lu();
    @(negedge clk); chk("ifid loaded", 64'(ifid_buf), 64'(16'hAFAF));
    step(); quiet(); buf_d = 16'h5555;
    @(negedge clk); chk("ifid held", 64'(ifid_buf), 64'(16'hAFAF));
    chk("idex bubbled", 64'(idex_buf), 64'(16'h0000));
    step(); br = 1;
    step(); quiet();
    @(negedge clk); chk("ifid flushed", 64'(ifid_buf), 64'(16'h0000));
    chk("idex flushed", 64'(idex_buf), 64'(16'h0000));

    // 5: halt, held 20 cycles, exit by reset
    step(); halt = 1;
    @(negedge clk); chk("halt entry ctrl", 64'(a_ctrl), 64'(E_STALL));
    chk("halt entry halted", 64'(a_halted), 64'(0));
    step(); halt = 0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) step();
      busy = (i == 5);
      @(negedge clk);
      chk("halted", 64'(a_halted), 64'(1));
      chk("halt ctrl", 64'(a_ctrl), 64'(E_STALL));
      chk("halt stall frozen", 64'(a_stall), 64'(11));
    end
    step(); quiet(); rst = 1;
    @(negedge clk); chk("halt reset ctrl", 64'(a_ctrl), 64'(E_RESET));
    step(); quiet();
    @(negedge clk); chk("run after reset", 64'(a_halted), 64'(0));
    chk("stall after reset", 64'(a_stall), 64'(0));

    // 6: saturation of the 4-bit counter
    step(); set_lu();
    repeat (19) step();
    step(); quiet();
    @(negedge clk); chk("w4 saturated", 64'(s_stall), 64'(4'hF));
    chk("w16 count", 64'(a_stall), 64'(20));

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
